decoder_2to4_seq: RTL
=====================

# decoder_2to4_seq

Registered 2-to-4 decoder that turns a {v, y[1:0]} code (the format produced by the 4-to-2 priority/valid encoders) back into a one-hot line held for a programmable number of cycles. The code is accepted over a valid/ready handshake. The block then drives the one-hot output, inserts an optional idle gap, and signals completion. It sits at the consumer end of encoded select/request buses.

## Interface
- HOLD, 4: cycles the one-hot output stays asserted; legal range ≥1.
- GAP, 1: idle cycles after HOLD before the next code is accepted; legal range ≥0.
- CNT_W, 8: width of the invalid-code counter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  code present on y/v.
- in_ready  out  1  block can accept a code this cycle.
- y  in  2  encoded index.
- v  in  1  code-valid flag from the encoder; v=0 means "no line active".
- D  out  4  one-hot decoded output, registered.
- busy  out  1  state ≠ IDLE.
- done  out  1  single-cycle pulse marking the end of a DRIVE period.
- inv_cnt  out  CNT_W  saturating count of accepted codes with v=0.

## Operation
- States: IDLE, DRIVE, GAP.
- A handshake occurs when in_valid && in_ready. in_ready is 1 only in IDLE and is combinational from state.
- IDLE, handshake with v=1:
  - latch y;
  - next state DRIVE;
  - D ← 4'b0001 << y;
  - load the down-counter with HOLD-1.
- IDLE, handshake with v=0:
  - stay in IDLE;
  - D stays 0;
  - inv_cnt increments, saturating at all-ones.
- DRIVE:
  - D holds its value; y/v/in_valid are ignored.
  - The counter decrements each cycle.
  - When the counter is 0: D ← 0 and done ← 1 for one cycle. Next state is GAP with the counter loaded to GAP-1 if GAP>0, otherwise IDLE.
- GAP:
  - D=0, in_ready=0, the counter decrements.
  - When the counter is 0, next state is IDLE.
- Counter width is $clog2(max(HOLD,GAP)+1), with a minimum of 1 bit. No wrap occurs; the counter is reloaded on each state entry.
- D is never multi-hot. It equals 0 in IDLE and GAP.

## Timing
- Reset values: state=IDLE, D=0, done=0, busy=0, inv_cnt=0, counter=0, in_ready=1 once reset deasserts.
- Reset asserted mid-DRIVE or mid-GAP clears D and done asynchronously. No done pulse is generated.
- For a handshake at edge k:
  - D is valid for cycles k+1 … k+HOLD;
  - done is high in cycle k+HOLD+1;
  - in_ready returns high in cycle k+HOLD+GAP+1.
- Minimum accept-to-accept spacing is HOLD+GAP+1 cycles.
- With in_valid held high continuously, a new code is accepted on the first IDLE cycle.
- A v=0 handshake costs 1 cycle and never raises busy.
- HOLD=1 and GAP=0: D is high for exactly one cycle, and done coincides with the IDLE cycle in which in_ready is already 1.

## Configuration
- DEC2TO4_INVCNT_EN defined: the inv_cnt register and its saturating increment are compiled in.
- DEC2TO4_INVCNT_EN undefined: inv_cnt is tied to 0, no counter flops exist, and v=0 handshakes are simply dropped.

## Structure
- Package/header dec2to4_pkg holds:
  - the state encoding: IDLE=2'd0, DRIVE=2'd1, GAP=2'd2;
  - the one-hot width constant ONEHOT_W=4.
- Sub-module decoder_2to4_comb is a purely combinational y → one-hot decode. It is instantiated once to form the next-D value.

## Test plan
- Reset, then y=2'b10, v=1, one-cycle in_valid (HOLD=4, GAP=1) → D=4'b0100 for 4 cycles, done pulses once, in_ready low for 5 cycles.
- in_valid held high, y sweeping 0..3 with v=1 → D sequence 0001, 0010, 0100, 1000, spaced 6 cycles apart, never multi-hot.
- y/v toggled during DRIVE → D unchanged until its HOLD expires.
- 300 consecutive v=0 handshakes with the macro defined → inv_cnt saturates at 255, D stays 0, busy stays 0. With the macro undefined → inv_cnt stays 0.
- rst asserted 2 cycles into DRIVE → D=0 immediately, no done pulse, in_ready=1 after release.
- HOLD=1, GAP=0, back-to-back codes → D high 1 cycle out of every 2, done aligned with in_ready.

Source files
------------

// File: rtl/dec2to4_pkg.sv
// Shared state encoding, one-hot width and counter sizing for the 2-to-4 decoder.
package dec2to4_pkg;

    localparam int unsigned ONEHOT_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StGap   = 2'd2
    } state_e;

    // Width needed to hold the larger of the two reload values, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/decoder_2to4_comb.sv
// Purely combinational 2-bit index to one-hot decode.
module decoder_2to4_comb
    import dec2to4_pkg::*;
(
    input  logic [1:0]          y,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        unique case (y)
            2'd0: onehot = 4'b0001;
            2'd1: onehot = 4'b0010;
            2'd2: onehot = 4'b0100;
            2'd3: onehot = 4'b1000;
            default: onehot = '0;
        endcase
    end

endmodule

// File: rtl/decoder_2to4_seq.sv
// Registered 2-to-4 decoder: accepts {v, y} over valid/ready, holds the one-hot line for HOLD
// cycles, then idles for GAP cycles. Invalid-code counter is built only with DEC2TO4_INVCNT_EN.
module decoder_2to4_seq
    import dec2to4_pkg::*;
#(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned GAP   = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          y,
    input  logic                v,
    output logic [ONEHOT_W-1:0] D,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    inv_cnt
);

    localparam int unsigned    CntW     = cnt_width(HOLD, GAP);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'((GAP > 0) ? (GAP - 1) : 0);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ONEHOT_W-1:0]   d_q, d_d;
    logic [ONEHOT_W-1:0]   onehot;
    logic                  done_q, done_d;
    logic                  hs;

    decoder_2to4_comb u_comb (
        .y      (y),
        .onehot (onehot)
    );

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign hs       = in_valid && in_ready;
    assign D        = d_q;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hs && v) begin
                    state_d = StDrive;
                    d_d     = onehot;
                    cnt_d   = HoldLoad;
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    d_d    = '0;
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                d_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

`ifdef DEC2TO4_INVCNT_EN
    logic [CNT_W-1:0] inv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= '0;
        end else if (hs && !v && (inv_q != '1)) begin
            inv_q <= inv_q + CNT_W'(1);
        end
    end

    assign inv_cnt = inv_q;
`else
    assign inv_cnt = '0;
`endif

endmodule
